// File: rtl/sixty_down_timer.sv
// Mod-60 BCD countdown timer: loads a 00..59 start value, steps down once per
// TICK_DIV clocks while running, and pulses done on reaching 00.
module sixty_down_timer #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       start,
  input  logic       pause,
  output logic [2:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       done
);

  localparam int unsigned PW = 16;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          done_q, done_d;

  logic          is_zero;
  logic          tick;
  logic          pause_eff;

  assign is_zero   = (tens_q == 3'd0) && (ones_q == 4'd0);
  assign tick      = (presc_q == TICK_LAST);
  // start outranks pause on the same edge
  assign pause_eff = pause && !start;

  // Next-state, prescaler and BCD decrement
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    done_d  = 1'b0;

    if (load) begin
      tens_d  = (load_tens > 3'd5) ? 3'd5 : load_tens;
      ones_d  = (load_ones > 4'd9) ? 4'd9 : load_ones;
      presc_d = '0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !is_zero) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (tick) begin
            presc_d = '0;
          end else if (!pause_eff) begin
            presc_d = presc_q + PW'(1);
          end
          if (pause_eff) begin
            state_d = PAUSE;
          end
          if (tick) begin
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else begin
              ones_d = 4'd9;
              tens_d = tens_q - 3'd1;
            end
            // The step that writes 00 ends the run, even on a pause edge
            if ((tens_q == 3'd0) && (ones_q == 4'd1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    running_d = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tens_q    <= 3'd5;
      ones_q    <= 4'd9;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign tens    = tens_q;
  assign ones    = ones_q;
  assign running = running_q;
  assign done    = done_q;

endmodule
